// File: rtl/uart_host_link_pkg.sv
// Shared constants and FSM state encodings for the UART host link.
package uart_host_link_pkg;

  localparam logic [7:0] HDR_TX    = 8'hAA;
  localparam logic [7:0] HDR_RX    = 8'h55;
  localparam logic [7:0] CMD_WORK  = 8'h00;
  localparam logic [7:0] CMD_LOOP  = 8'h01;
  localparam logic [7:0] LEN_WORK  = 8'h58;
  localparam logic [7:0] LEN_NONCE = 8'h04;
  localparam logic [7:0] LEN_LOOP  = 8'h01;

  localparam int unsigned FRAME_BITS    = 728;
  localparam logic [6:0]  WORK_LAST_IDX = 7'd90;
  localparam logic [6:0]  LOOP_LAST_IDX = 7'd3;

  typedef enum logic [1:0] {
    T_IDLE,
    T_SEND,
    T_WBUSY,
    T_WEND
  } tx_state_t;

  typedef enum logic [1:0] {
    R_HDR,
    R_CMD,
    R_LEN,
    R_DAT
  } rx_state_t;

endpackage

// File: rtl/uart_host_rx.sv
// Response deframer: parses 0x55-headed nonce/loop frames with an inter-byte timeout.
module uart_host_rx
  import uart_host_link_pkg::*;
#(
  parameter logic [15:0] RX_TIMEOUT = 16'd50000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        new_rx_data,
  output logic        nonce_valid,
  output logic [31:0] nonce,
  output logic        loop_ack,
  output logic [7:0]  loop_ack_data,
  output logic        frame_err
);

  rx_state_t   state, state_n;
  logic        cmd_loop_q;
  logic [1:0]  byte_cnt;
  logic [23:0] nonce_sr;
  logic [15:0] to_cnt;
  logic        err_n, found_n, ack_n;
  logic [1:0]  last_cnt;
  logic [7:0]  len_exp;

  assign last_cnt = cmd_loop_q ? 2'd0 : 2'd3;
  assign len_exp  = cmd_loop_q ? LEN_LOOP : LEN_NONCE;

  always_comb begin
    state_n = state;
    err_n   = 1'b0;
    found_n = 1'b0;
    ack_n   = 1'b0;
    if (new_rx_data) begin
      case (state)
        R_HDR: if (rx_data == HDR_RX) state_n = R_CMD;
        R_CMD: begin
          if ((rx_data == CMD_WORK) || (rx_data == CMD_LOOP)) begin
            state_n = R_LEN;
          end else begin
            err_n   = 1'b1;
            state_n = R_HDR;
          end
        end
        R_LEN: begin
          if (rx_data == len_exp) begin
            state_n = R_DAT;
          end else begin
            err_n   = 1'b1;
            state_n = R_HDR;
          end
        end
        R_DAT: begin
          if (byte_cnt == last_cnt) begin
            state_n = R_HDR;
            found_n = ~cmd_loop_q;
            ack_n   = cmd_loop_q;
          end
        end
        default: state_n = R_HDR;
      endcase
    end else if ((state != R_HDR) && (to_cnt == RX_TIMEOUT - 16'd1)) begin
      err_n   = 1'b1;
      state_n = R_HDR;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= R_HDR;
      cmd_loop_q    <= 1'b0;
      byte_cnt      <= '0;
      nonce_sr      <= '0;
      to_cnt        <= '0;
      nonce_valid   <= 1'b0;
      nonce         <= '0;
      loop_ack      <= 1'b0;
      loop_ack_data <= '0;
      frame_err     <= 1'b0;
    end else begin
      state       <= state_n;
      frame_err   <= err_n;
      nonce_valid <= found_n;
      loop_ack    <= ack_n;
      if (new_rx_data && (state == R_CMD)) cmd_loop_q <= (rx_data == CMD_LOOP);
      if (state == R_LEN) begin
        byte_cnt <= '0;
      end else if (new_rx_data && (state == R_DAT)) begin
        byte_cnt <= byte_cnt + 2'd1;
        nonce_sr <= {rx_data, nonce_sr[23:8]};
      end
      // Little-endian assembly: final byte lands in the top of the nonce.
      if (found_n) nonce <= {rx_data, nonce_sr};
      if (ack_n) loop_ack_data <= rx_data;
      if (new_rx_data || (state_n == R_HDR)) begin
        to_cnt <= '0;
      end else if (to_cnt != '1) begin
        to_cnt <= to_cnt + 16'd1;
      end
    end
  end

endmodule

// File: rtl/uart_host_link.sv
// Host link: frames work/loop requests out over UART and deframes responses.
module uart_host_link
  import uart_host_link_pkg::*;
#(
  parameter logic [15:0] RX_TIMEOUT = 16'd50000
) (
  input  logic         clock,
  input  logic         reset,
  output logic [7:0]   tx_data,
  output logic         new_tx_data,
  input  logic         tx_busy,
  input  logic [7:0]   rx_data,
  input  logic         new_rx_data,
  output logic         cmd_ready,
  input  logic         work_valid,
  input  logic [639:0] work,
  input  logic [63:0]  target,
  input  logic         loop_req,
  input  logic [7:0]   loop_data,
  output logic         nonce_valid,
  output logic [31:0]  nonce,
  output logic         loop_ack,
  output logic [7:0]   loop_ack_data,
  output logic         frame_err
);

  tx_state_t             tx_state, tx_state_n;
  logic [6:0]            tx_idx;
  logic [6:0]            tx_last;
  logic                  is_loop_q;
  logic [FRAME_BITS-1:0] frame_q;
  logic                  accept, send, advance;

  assign cmd_ready = (tx_state == T_IDLE);
  assign tx_last   = is_loop_q ? LOOP_LAST_IDX : WORK_LAST_IDX;

  always_comb begin
    tx_state_n = tx_state;
    accept     = 1'b0;
    send       = 1'b0;
    advance    = 1'b0;
    case (tx_state)
      T_IDLE: begin
        if (work_valid || loop_req) begin
          accept     = 1'b1;
          tx_state_n = T_SEND;
        end
      end
      T_SEND: begin
        if (!tx_busy) begin
          send       = 1'b1;
          tx_state_n = T_WBUSY;
        end
      end
      T_WBUSY: if (tx_busy) tx_state_n = T_WEND;
      T_WEND: begin
        if (!tx_busy) begin
          if (tx_idx == tx_last) begin
            tx_state_n = T_IDLE;
          end else begin
            advance    = 1'b1;
            tx_state_n = T_SEND;
          end
        end
      end
      default: tx_state_n = T_IDLE;
    endcase
  end

  // The whole frame is captured as one shift register; byte 0 is always in [7:0].
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tx_state    <= T_IDLE;
      tx_idx      <= '0;
      is_loop_q   <= 1'b0;
      frame_q     <= '0;
      tx_data     <= '0;
      new_tx_data <= 1'b0;
    end else begin
      tx_state    <= tx_state_n;
      new_tx_data <= send;
      if (send) tx_data <= frame_q[7:0];
      if (accept) begin
        tx_idx    <= '0;
        is_loop_q <= ~work_valid;
        if (work_valid) begin
          frame_q <= {target, work, LEN_WORK, CMD_WORK, HDR_TX};
        end else begin
          frame_q <= {{(FRAME_BITS-32){1'b0}}, loop_data, LEN_LOOP, CMD_LOOP, HDR_TX};
        end
      end else if (advance) begin
        tx_idx  <= tx_idx + 7'd1;
        frame_q <= {8'h00, frame_q[FRAME_BITS-1:8]};
      end
    end
  end

  uart_host_rx #(
    .RX_TIMEOUT(RX_TIMEOUT)
  ) u_rx (
    .clock        (clock),
    .reset        (reset),
    .rx_data      (rx_data),
    .new_rx_data  (new_rx_data),
    .nonce_valid  (nonce_valid),
    .nonce        (nonce),
    .loop_ack     (loop_ack),
    .loop_ack_data(loop_ack_data),
    .frame_err    (frame_err)
  );

endmodule

// File: tb/tb_uart_host_link.sv
// Self-checking bench for uart_host_link: TX byte scoreboard, RX event scoreboard.
module tb_uart_host_link;

  localparam int unsigned RX_TO = 40;

  logic         clock = 1'b0;
  logic         reset;
  logic [7:0]   tx_data;
  logic         new_tx_data;
  logic         tx_busy;
  logic [7:0]   rx_data;
  logic         new_rx_data;
  logic         cmd_ready;
  logic         work_valid;
  logic [639:0] work;
  logic [63:0]  target;
  logic         loop_req;
  logic [7:0]   loop_data;
  logic         nonce_valid;
  logic [31:0]  nonce;
  logic         loop_ack;
  logic [7:0]   loop_ack_data;
  logic         frame_err;

  uart_host_link #(.RX_TIMEOUT(16'(RX_TO))) dut (
    .clock        (clock),
    .reset        (reset),
    .tx_data      (tx_data),
    .new_tx_data  (new_tx_data),
    .tx_busy      (tx_busy),
    .rx_data      (rx_data),
    .new_rx_data  (new_rx_data),
    .cmd_ready    (cmd_ready),
    .work_valid   (work_valid),
    .work         (work),
    .target       (target),
    .loop_req     (loop_req),
    .loop_data    (loop_data),
    .nonce_valid  (nonce_valid),
    .nonce        (nonce),
    .loop_ack     (loop_ack),
    .loop_ack_data(loop_ack_data),
    .frame_err    (frame_err)
  );

  always #5 clock = ~clock;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned tx_cnt = 0;

  typedef struct {
    int          kind;   // 0 nonce, 1 loop ack, 2 frame error
    logic [31:0] data;
  } rx_ev_t;

  typedef struct {
    int unsigned n;
    logic [63:0] bytes;  // first byte in [7:0]
    int          kind;
    logic [31:0] data;
  } rx_vec_t;

  logic [7:0] tx_exp[$];
  rx_ev_t     rx_exp[$];
  rx_vec_t    vecs[9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // UART transmitter model: 10 cycles busy per byte, compares against the scoreboard.
  initial begin
    tx_busy = 1'b0;
    forever begin
      @(negedge clock);
      if (new_tx_data === 1'b1) begin
        tx_cnt++;
        checks++;
        if (tx_exp.size() == 0) begin
          errors++;
          $display("FAIL tx_unexpected byte=%0h count=%0d", tx_data, tx_cnt);
        end else begin
          automatic logic [7:0] e = tx_exp.pop_front();
          if (tx_data !== e) begin
            errors++;
            $display("FAIL tx_byte count=%0d actual=%0h required=%0h", tx_cnt, tx_data, e);
          end
        end
        tx_busy = 1'b1;
        repeat (10) @(negedge clock);
        tx_busy = 1'b0;
      end
    end
  end

  // Receive-side monitor: every pulse must match the next expected event.
  initial begin
    forever begin
      @(negedge clock);
      if ((nonce_valid === 1'b1) || (loop_ack === 1'b1) || (frame_err === 1'b1)) begin
        automatic int k = frame_err ? 2 : (loop_ack ? 1 : 0);
        checks++;
        if (rx_exp.size() == 0) begin
          errors++;
          $display("FAIL rx_unexpected kind=%0d nonce=%0h ack=%0h", k, nonce, loop_ack_data);
        end else begin
          automatic rx_ev_t e = rx_exp.pop_front();
          if ((k != e.kind) || (32'(nonce_valid) + 32'(loop_ack) + 32'(frame_err) != 1) ||
              ((k == 0) && (nonce !== e.data)) ||
              ((k == 1) && (32'(loop_ack_data) !== e.data))) begin
            errors++;
            $display("FAIL rx_event kind=%0d nonce=%0h ack=%0h required kind=%0d data=%0h",
                     k, nonce, loop_ack_data, e.kind, e.data);
          end
        end
      end
    end
  end

  task automatic rx_byte(input logic [7:0] b, input int unsigned gap);
    @(negedge clock);
    rx_data     = b;
    new_rx_data = 1'b1;
    @(negedge clock);
    new_rx_data = 1'b0;
    repeat (gap) @(negedge clock);
  endtask

  task automatic push_rx(input int kind, input logic [31:0] data);
    rx_ev_t e;
    e.kind = kind;
    e.data = data;
    rx_exp.push_back(e);
  endtask

  task automatic wait_ready(input int unsigned limit, input string name);
    int unsigned n = 0;
    while (!cmd_ready && n < limit) begin
      @(negedge clock);
      n++;
    end
    check(name, 64'(cmd_ready), 64'd1);
  endtask

  task automatic request(input logic wv, input logic lr);
    @(negedge clock);
    work_valid = wv;
    loop_req   = lr;
    @(negedge clock);
    work_valid = 1'b0;
    loop_req   = 1'b0;
    check("cmd_ready_drop", 64'(cmd_ready), 64'd0);
  endtask

  task automatic push_work_frame();
    tx_exp.push_back(8'hAA);
    tx_exp.push_back(8'h00);
    tx_exp.push_back(8'h58);
    for (int i = 0; i < 80; i++) tx_exp.push_back(work[8*i +: 8]);
    for (int i = 0; i < 8; i++) tx_exp.push_back(target[8*i +: 8]);
  endtask

  initial begin
    int unsigned n;
    int unsigned start;
    reset       = 1'b1;
    work_valid  = 1'b0;
    loop_req    = 1'b0;
    work        = '0;
    target      = '0;
    loop_data   = '0;
    rx_data     = '0;
    new_rx_data = 1'b0;

    vecs[0] = '{n: 7, bytes: 64'h0012_3456_7804_0055, kind: 0, data: 32'h1234_5678};
    vecs[1] = '{n: 4, bytes: 64'h0000_0000_3D01_0155, kind: 1, data: 32'h3D};
    vecs[2] = '{n: 3, bytes: 64'h0000_0000_0002_0055, kind: 2, data: 32'h0};
    vecs[3] = '{n: 4, bytes: 64'h0000_0000_0701_0155, kind: 1, data: 32'h07};
    vecs[4] = '{n: 5, bytes: 64'h0000_00A5_0101_5512, kind: 1, data: 32'hA5};
    vecs[5] = '{n: 2, bytes: 64'h0000_0000_0000_0255, kind: 2, data: 32'h0};
    vecs[6] = '{n: 3, bytes: 64'h0000_0000_0004_0155, kind: 2, data: 32'h0};
    vecs[7] = '{n: 7, bytes: 64'h0004_0302_0104_0055, kind: 0, data: 32'h0403_0201};
    vecs[8] = '{n: 3, bytes: 64'h0000_0000_0001_0055, kind: 2, data: 32'h0};

    repeat (2) @(negedge clock);
    check("rst_tx_data", 64'(tx_data), 64'd0);
    check("rst_new_tx_data", 64'(new_tx_data), 64'd0);
    check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    check("rst_nonce_valid", 64'(nonce_valid), 64'd0);
    check("rst_nonce", 64'(nonce), 64'd0);
    check("rst_loop_ack", 64'(loop_ack), 64'd0);
    check("rst_loop_ack_data", 64'(loop_ack_data), 64'd0);
    check("rst_frame_err", 64'(frame_err), 64'd0);
    reset = 1'b0;
    repeat (2) @(negedge clock);

    // Loop frame; payload changed right after acceptance must not leak in.
    loop_data = 8'h3C;
    tx_exp.push_back(8'hAA);
    tx_exp.push_back(8'h01);
    tx_exp.push_back(8'h01);
    tx_exp.push_back(8'h3C);
    request(1'b0, 1'b1);
    loop_data = 8'hC3;
    wait_ready(200, "loop_done");
    check("loop_tx_count", 64'(tx_cnt), 64'd4);

    // Work frame, with the RX tests running underneath it.
    for (int i = 0; i < 80; i++) work[8*i +: 8] = 8'(8'h11 + i);
    for (int i = 0; i < 8; i++) target[8*i +: 8] = 8'(8'h92 + i);
    push_work_frame();
    request(1'b1, 1'b0);
    work   = {80{8'hEE}};
    target = {8{8'hDD}};
    check("work_busy_midframe", 64'(cmd_ready), 64'd0);

    for (int v = 0; v < 9; v++) begin
      push_rx(vecs[v].kind, vecs[v].data);
      for (int unsigned b = 0; b < vecs[v].n; b++) begin
        automatic logic [63:0] bv = vecs[v].bytes;
        rx_byte(bv[8*b +: 8], 2);
      end
      repeat (4) @(negedge clock);
    end
    check("nonce_held", 64'(nonce), 64'h0403_0201);

    // Exact pulse timing for a nonce frame.
    push_rx(0, 32'h1234_5678);
    rx_byte(8'h55, 1);
    rx_byte(8'h00, 1);
    rx_byte(8'h04, 1);
    rx_byte(8'h78, 1);
    rx_byte(8'h56, 1);
    rx_byte(8'h34, 1);
    rx_byte(8'h12, 0);
    check("nonce_pulse", 64'(nonce_valid), 64'd1);
    check("nonce_value", 64'(nonce), 64'h1234_5678);
    @(negedge clock);
    check("nonce_pulse_single", 64'(nonce_valid), 64'd0);

    // Inter-byte timeout, then recovery.
    push_rx(2, 32'h0);
    rx_byte(8'h55, 1);
    rx_byte(8'h00, 1);
    rx_byte(8'h04, 1);
    rx_byte(8'hAB, 0);
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!frame_err && n < 200);
    check("timeout_cycles", 64'(n), 64'(RX_TO));
    push_rx(1, 32'h5A);
    rx_byte(8'h55, 1);
    rx_byte(8'h01, 1);
    rx_byte(8'h01, 1);
    rx_byte(8'h5A, 4);

    wait_ready(3000, "work_done");
    check("work_tx_count", 64'(tx_cnt), 64'd95);
    check("tx_queue_empty", 64'(tx_exp.size()), 64'd0);

    // Simultaneous requests: work wins; reset aborts it at byte 40.
    for (int i = 0; i < 80; i++) work[8*i +: 8] = 8'(8'h80 ^ i);
    target    = 64'h0102_0304_0506_0708;
    loop_data = 8'hE7;
    push_work_frame();
    start = tx_cnt;
    request(1'b1, 1'b1);
    n = 0;
    while ((tx_cnt < start + 40) && n < 2000) begin
      @(negedge clock);
      n++;
    end
    check("reach_byte40", 64'(tx_cnt - start), 64'd40);
    reset = 1'b1;
    tx_exp.delete();
    @(negedge clock);
    check("abort_new_tx_data", 64'(new_tx_data), 64'd0);
    check("abort_cmd_ready", 64'(cmd_ready), 64'd1);
    check("abort_nonce_clr", 64'(nonce), 64'd0);
    reset = 1'b0;
    start = tx_cnt;
    repeat (60) @(negedge clock);
    check("abort_no_more_tx", 64'(tx_cnt), 64'(start));
    check("abort_ready_hold", 64'(cmd_ready), 64'd1);
    check("rx_queue_empty", 64'(rx_exp.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_host_link.md
UART_HOST_LINK -- requirements
Module: uart_host_link

Interface
REQ-001 SHALL have parameter RX_TIMEOUT, default 16'd50000, meaning idle cycles allowed between bytes of one response frame.
REQ-002 SHALL have port clock  input  1  system clock, rising edge.
REQ-003 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port tx_data  output  8  byte to the UART transmitter.
REQ-005 SHALL have port new_tx_data  output  1  one-cycle strobe, tx_data valid.
REQ-006 SHALL have port tx_busy  input  1  UART transmitter busy.
REQ-007 SHALL have port rx_data  input  8  byte from the UART receiver.
REQ-008 SHALL have port new_rx_data  input  1  one-cycle strobe, rx_data valid.
REQ-009 SHALL have port cmd_ready  output  1  ready to accept a work or loop request.
REQ-010 SHALL have port work_valid  input  1  work request, qualified by cmd_ready.
REQ-011 SHALL have port work  input  640  80-byte work block.
REQ-012 SHALL have port target  input  64  hash target.
REQ-013 SHALL have port loop_req  input  1  loop-test request, qualified by cmd_ready.
REQ-014 SHALL have port loop_data  input  8  loop-test payload.
REQ-015 SHALL have port nonce_valid  output  1  one-cycle pulse, nonce holds a found nonce.
REQ-016 SHALL have port nonce  output  32  last found nonce.
REQ-017 SHALL have port loop_ack  output  1  one-cycle pulse, loop_ack_data holds the returned byte.
REQ-018 SHALL have port loop_ack_data  output  8  payload of the last loop acknowledge.
REQ-019 SHALL have port frame_err  output  1  one-cycle pulse on a malformed or timed-out response frame.

Function
REQ-020 SHALL accept a request in a cycle where cmd_ready=1 and work_valid or loop_req is 1; work_valid SHALL win when both are 1, and loop_req SHALL then be ignored.
REQ-021 SHALL drive cmd_ready=0 from the cycle after acceptance until the last frame byte has completed (tx_busy falling edge).
REQ-022 A work frame SHALL be 91 bytes: 0xAA, 0x00, 0x58, work[7:0] to work[639:632] in ascending byte order, then target[7:0] to target[63:56].
REQ-023 A loop frame SHALL be 4 bytes: 0xAA, 0x01, 0x01, loop_data.
REQ-024 work, target and loop_data SHALL be captured at acceptance; later input changes SHALL NOT affect the frame in flight.
REQ-025 Transmit FSM states: T_IDLE, T_SEND, T_WBUSY, T_WEND.
REQ-026 T_SEND SHALL issue new_tx_data for one cycle when tx_busy=0, then move to T_WBUSY.
REQ-027 T_WBUSY SHALL move to T_WEND on tx_busy=1; T_WEND SHALL move to T_SEND on tx_busy=0, or to T_IDLE when the byte just sent was the last.
REQ-028 The transmit byte index SHALL be 7 bits, SHALL count 0..90, and SHALL NOT wrap.
REQ-029 Receive FSM states: R_HDR, R_CMD, R_LEN, R_DAT; it SHALL advance only on new_rx_data.
REQ-030 R_HDR SHALL go to R_CMD on 0x55 and stay in R_HDR on any other byte, with no error.
REQ-031 R_CMD SHALL go to R_LEN on 0x00 or 0x01; any other byte SHALL pulse frame_err and return to R_HDR.
REQ-032 R_LEN SHALL require 0x04 for command 0x00 and 0x01 for command 0x01; a mismatch SHALL pulse frame_err and return to R_HDR.
REQ-033 In R_DAT, the found frame SHALL assemble nonce little-endian (first byte -> nonce[7:0]).
REQ-034 nonce_valid or loop_ack SHALL pulse in the cycle after the final data byte is accepted; nonce and loop_ack_data SHALL update in that same cycle and then hold.
REQ-035 In R_CMD, R_LEN or R_DAT, RX_TIMEOUT cycles without new_rx_data SHALL pulse frame_err and return to R_HDR; the timeout counter SHALL saturate and reset on each new_rx_data.
REQ-036 The transmit and receive paths SHALL be independent; a response arriving mid-transmit SHALL be parsed normally.

Reset
REQ-037 On reset, outputs SHALL go to: tx_data=0, new_tx_data=0, cmd_ready=1, nonce_valid=0, nonce=0, loop_ack=0, loop_ack_data=0, frame_err=0.
REQ-038 On reset, both FSMs SHALL go to T_IDLE / R_HDR, all counters SHALL clear, and the frame in flight SHALL be abandoned without completion.

Structure
REQ-039 A shared package SHALL hold header bytes 0xAA/0x55, command codes 0x00/0x01, lengths 0x58/0x04/0x01, and the FSM state encodings.
REQ-040 The receive deframer SHALL be the sub-module uart_host_rx.

Verification
REQ-041 Work (work[7:0]=0x11, target[63:56]=0x99), UART model with busy of 10 cycles -> 91 strobes: AA 00 58 11 ... 99; cmd_ready returns to 1 after the last.
REQ-042 loop_req with loop_data=0x3C -> AA 01 01 3C; then injecting rx 55 01 01 3D -> loop_ack pulse with loop_ack_data=0x3D.
REQ-043 rx 55 00 04 78 56 34 12 -> nonce=0x12345678, with a single nonce_valid pulse one cycle after 0x12.
REQ-044 rx 55 00 02 -> frame_err pulse; then 55 01 01 07 -> loop_ack, loop_ack_data=0x07.
REQ-045 rx 55 00 04 AB, then silence for RX_TIMEOUT cycles -> frame_err; a following valid frame is parsed correctly.
REQ-046 work_valid and loop_req together -> work frame only; reset asserted at byte 40 -> new_tx_data stops, cmd_ready=1.
